// File: rtl/ph_track_est_gen.sv
// Pilot phase-tracking estimator: derives common phase and slope from one symbol's pilots,
// then streams per-subcarrier correction vectors ph = init + k*step (DC-gap jump, optional IIR).
module ph_track_est_gen #(
  parameter int DW       = 16,
  parameter int NPIL     = 8,
  parameter int NSC      = 192,
  parameter int SLOPE_SH = 7,
  parameter int HALF_SH  = 6,
  parameter int SKIP_IDX = 95,
  parameter int SKIP_SH  = 1,
  parameter int ALPHA_SH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 smooth_en,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  input  logic                 din_val,
  output logic                 din_rdy,
  input  logic                 acc,
  output logic signed [DW-1:0] ph_re,
  output logic signed [DW-1:0] ph_im,
  output logic [7:0]           sc_idx,
  output logic                 est_done,
  output logic                 busy
);

  localparam int LG = $clog2(NPIL);
  localparam int AW = DW + LG;
  localparam int IW = DW + 2;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CALC, S_SMOOTH, S_LOAD, S_READY} state_t;
  state_t state, state_nxt;

  logic signed [AW-1:0] sum_all_re, sum_all_im, sum_hi_re, sum_hi_im;
  logic signed [AW-1:0] din_re_x, din_im_x;
  logic [LG-1:0]        pil_cnt;
  logic signed [IW-1:0] new_com_re, new_com_im, new_step_re, new_step_im;
  logic signed [IW-1:0] com_re, com_im, step_re, step_im;
  logic signed [IW-1:0] run_re, run_im;
  logic                 hist_valid;

  logic signed [AW:0]   diff_re, diff_im, step_sh_re, step_sh_im;
  logic signed [AW-1:0] com_sh_re, com_sh_im;
  logic signed [IW-1:0] init_re, init_im, inc_re, inc_im, run_nxt_re, run_nxt_im;
  logic                 do_load, do_step;

  function automatic logic signed [DW-1:0] sat(input logic signed [IW-1:0] v);
    if (v[IW-1:DW-1] == {(IW-DW+1){v[IW-1]}}) return v[DW-1:0];
    else if (v[IW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // One-pole IIR; the difference is formed one bit wider so it cannot wrap
  function automatic logic signed [IW-1:0] iir(input logic signed [IW-1:0] x,
                                               input logic signed [IW-1:0] n);
    logic signed [IW:0] d;
    d = $signed({n[IW-1], n}) - $signed({x[IW-1], x});
    d = d >>> ALPHA_SH;
    return x + d[IW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_rdy   = 1'b0;
    busy      = 1'b0;
    case (state)
      S_COLLECT: begin
        din_rdy = 1'b1;
        busy    = 1'b1;
        if (din_val && pil_cnt == LG'(NPIL-1)) state_nxt = S_CALC;
      end
      S_CALC:   begin busy = 1'b1; state_nxt = S_SMOOTH; end
      S_SMOOTH: begin busy = 1'b1; state_nxt = S_LOAD; end
      S_LOAD:   begin busy = 1'b1; state_nxt = S_READY; end
      default:  state_nxt = state;
    endcase
    if (start) state_nxt = S_COLLECT;
  end

  assign din_re_x   = {{LG{din_re[DW-1]}}, din_re};
  assign din_im_x   = {{LG{din_im[DW-1]}}, din_im};
  assign diff_re    = $signed({sum_hi_re, 1'b0}) - $signed({sum_all_re[AW-1], sum_all_re});
  assign diff_im    = $signed({sum_hi_im, 1'b0}) - $signed({sum_all_im[AW-1], sum_all_im});
  assign step_sh_re = diff_re >>> SLOPE_SH;
  assign step_sh_im = diff_im >>> SLOPE_SH;
  assign com_sh_re  = sum_all_re >>> LG;
  assign com_sh_im  = sum_all_im >>> LG;

  // The running value stays unsaturated so the output recovers once back in range
  assign init_re    = com_re - (step_re <<< HALF_SH);
  assign init_im    = com_im - (step_im <<< HALF_SH);
  assign inc_re     = (sc_idx == 8'(SKIP_IDX)) ? (step_re <<< SKIP_SH) : step_re;
  assign inc_im     = (sc_idx == 8'(SKIP_IDX)) ? (step_im <<< SKIP_SH) : step_im;
  assign run_nxt_re = (state == S_LOAD) ? init_re : run_re + inc_re;
  assign run_nxt_im = (state == S_LOAD) ? init_im : run_im + inc_im;
  assign do_load    = (state == S_LOAD) && !start;
  assign do_step    = (state == S_READY) && acc && !start && (sc_idx < 8'(NSC-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_all_re  <= '0;
      sum_all_im  <= '0;
      sum_hi_re   <= '0;
      sum_hi_im   <= '0;
      pil_cnt     <= '0;
      new_com_re  <= '0;
      new_com_im  <= '0;
      new_step_re <= '0;
      new_step_im <= '0;
      com_re      <= '0;
      com_im      <= '0;
      step_re     <= '0;
      step_im     <= '0;
      run_re      <= '0;
      run_im      <= '0;
      hist_valid  <= 1'b0;
      ph_re       <= '0;
      ph_im       <= '0;
      sc_idx      <= '0;
      est_done    <= 1'b0;
    end else begin
      est_done <= 1'b0;
      if (start) begin
        sum_all_re <= '0;
        sum_all_im <= '0;
        sum_hi_re  <= '0;
        sum_hi_im  <= '0;
        pil_cnt    <= '0;
      end else if (din_val && din_rdy) begin
        sum_all_re <= sum_all_re + din_re_x;
        sum_all_im <= sum_all_im + din_im_x;
        if (pil_cnt[LG-1]) begin
          sum_hi_re <= sum_hi_re + din_re_x;
          sum_hi_im <= sum_hi_im + din_im_x;
        end
        pil_cnt <= pil_cnt + 1'b1;
      end
      if (state == S_CALC) begin
        new_com_re  <= {{2{com_sh_re[DW-1]}}, com_sh_re[DW-1:0]};
        new_com_im  <= {{2{com_sh_im[DW-1]}}, com_sh_im[DW-1:0]};
        new_step_re <= step_sh_re[IW-1:0];
        new_step_im <= step_sh_im[IW-1:0];
      end
      if (state == S_SMOOTH && !start) begin
        if (smooth_en && hist_valid) begin
          com_re  <= iir(com_re, new_com_re);
          com_im  <= iir(com_im, new_com_im);
          step_re <= iir(step_re, new_step_re);
          step_im <= iir(step_im, new_step_im);
        end else begin
          com_re  <= new_com_re;
          com_im  <= new_com_im;
          step_re <= new_step_re;
          step_im <= new_step_im;
        end
        hist_valid <= 1'b1;
      end
      if (do_load || do_step) begin
        run_re <= run_nxt_re;
        run_im <= run_nxt_im;
        ph_re  <= sat(run_nxt_re);
        ph_im  <= sat(run_nxt_im);
        sc_idx <= do_load ? 8'd0 : sc_idx + 8'd1;
      end
      if (do_load) est_done <= 1'b1;
    end
  end

endmodule
